board_draw_scheduler: RTL and testbench

//  Shares the single VGA pixel-plot port between two board requesters (player 0 = left board,

---
 rtl/board_draw_pkg.sv | 17 +
 rtl/board_draw_scheduler_rr_arb2.sv | 21 ++
 rtl/board_draw_scheduler.sv | 114 +++++++++++
 tb/tb_board_draw_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_draw_pkg.sv
// board_draw_pkg: shared geometry, colour constants and FSM state type for the board draw scheduler
package board_draw_pkg;
  localparam logic [8:0] BASEX_LEFT  = 9'd10;
  localparam logic [8:0] BASEX_RIGHT = 9'd178;
  localparam logic [7:0] BASEY       = 8'd91;
  localparam logic [8:0] CELL_PITCH  = 9'd14;
  localparam logic [3:0] MARK_SIZE   = 4'd12;
  localparam logic [3:0] GRID_MAX    = 4'd9;
  localparam logic [2:0] COL_MISS    = 3'b111;
  localparam logic [2:0] COL_HIT     = 3'b100;
  localparam logic [2:0] COL_SUNK    = 3'b101;
  localparam logic [2:0] COL_BG      = 3'b000;
  typedef enum logic [2:0] {CLEAR, IDLE, DIAG, ANTI, DONE} state_t;
  function automatic logic [2:0] mark_colour(input logic [1:0] m);
    return m == 2'd0 ? COL_MISS : m == 2'd1 ? COL_HIT : m == 2'd2 ? COL_SUNK : COL_BG;
  endfunction
endpackage

// File: rtl/board_draw_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; last_grant only moves when both requesters collide
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);
  logic r_last;
  logic w_tie;
  always_comb begin
    w_tie  = i_en && i_req0 && i_req1;
    o_gnt0 = i_en && i_req0 && (!i_req1 || r_last);
    o_gnt1 = i_en && i_req1 && (!i_req0 || !r_last);
  end
  always_ff @(posedge clk)
    if (!rst_n) r_last <= 1'b1;
    else if (w_tie) r_last <= o_gnt1;
endmodule

// File: rtl/board_draw_scheduler.sv
// board_draw_scheduler: shares the VGA plot port between two boards, clearing the frame after reset
module board_draw_scheduler
  import board_draw_pkg::*;
#(
  parameter int SCREEN_W       = 320,
  parameter int SCREEN_H       = 240,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic [3:0] i_x0,
  input  logic [3:0] i_y0,
  input  logic [3:0] i_x1,
  input  logic [3:0] i_y1,
  input  logic [1:0] i_mark0,
  input  logic [1:0] i_mark1,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic       o_err,
  output logic       o_done,
  output logic       o_busy,
  output logic [8:0] o_vga_x,
  output logic [7:0] o_vga_y,
  output logic [2:0] o_vga_colour,
  output logic       o_vga_plot
);
  localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);
  state_t r_state, w_state_nxt;
  logic [8:0] r_cx, r_bx, r_x, w_bx, w_px;
  logic [7:0] r_cy, r_by, r_y, w_by, w_py;
  logic [3:0] r_i, w_gx, w_gy;
  logic [2:0] r_col, r_colour, w_pc;
  logic r_ack0, r_ack1, r_err, r_done, r_busy, r_plot;
  logic w_en, w_gnt0, w_gnt1, w_grant, w_bad, w_last_px, w_cross, w_plot;
  // The registered ack is still visible for one cycle; blocking on it stops a re-grant of an err request.
  assign w_en = r_state == IDLE && !r_ack0 && !r_ack1;
  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_req0 (i_req0),
    .i_req1 (i_req1),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );
  always_comb begin
    w_grant   = w_gnt0 || w_gnt1;
    w_gx      = w_gnt1 ? i_x1 : i_x0;
    w_gy      = w_gnt1 ? i_y1 : i_y0;
    w_bad     = w_gx > GRID_MAX || w_gy > GRID_MAX;
    w_bx      = (w_gnt1 ? BASEX_RIGHT : BASEX_LEFT) + CELL_PITCH * 9'(w_gx);
    w_by      = BASEY + 8'(CELL_PITCH) * 8'(w_gy);
    w_last_px = r_cx == X_LAST && r_cy == Y_LAST;
    w_cross   = r_state == DIAG || r_state == ANTI;
  end
  always_ff @(posedge clk)
    if (!rst_n) r_state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   w_state_nxt = w_last_px ? DONE : CLEAR;
      IDLE:    w_state_nxt = w_grant && !w_bad ? DIAG : IDLE;
      DIAG:    w_state_nxt = r_i == MARK_SIZE - 4'd1 ? ANTI : DIAG;
      ANTI:    w_state_nxt = r_i == MARK_SIZE - 4'd1 ? DONE : ANTI;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    w_plot = r_state == CLEAR || w_cross;
    w_px   = r_state == CLEAR ? r_cx :
             r_state == DIAG  ? r_bx + 9'(r_i) :
             r_state == ANTI  ? r_bx + 9'(MARK_SIZE - 4'd1 - r_i) : r_x;
    w_py   = r_state == CLEAR ? r_cy : w_cross ? r_by + 8'(r_i) : r_y;
    w_pc   = r_state == CLEAR ? COL_BG : w_cross ? r_col : r_colour;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      {r_ack0, r_ack1, r_err, r_done, r_busy, r_plot} <= '0;
      {r_x, r_y, r_colour, r_cx, r_cy, r_i} <= '0;
      {r_bx, r_by, r_col} <= '0;
    end else begin
      r_ack0   <= w_gnt0;
      r_ack1   <= w_gnt1;
      r_err    <= w_grant && w_bad;
      r_done   <= r_state == DONE;
      r_busy   <= w_plot;
      r_plot   <= w_plot;
      r_x      <= w_px;
      r_y      <= w_py;
      r_colour <= w_pc;
      r_cx     <= r_state != CLEAR ? 9'd0 : r_cx == X_LAST ? 9'd0 : r_cx + 9'd1;
      r_cy     <= r_state != CLEAR ? 8'd0 : r_cx != X_LAST ? r_cy : r_cy == Y_LAST ? 8'd0 : r_cy + 8'd1;
      r_i      <= !w_cross ? 4'd0 : r_i == MARK_SIZE - 4'd1 ? 4'd0 : r_i + 4'd1;
      if (w_grant) begin
        r_bx  <= w_bx;
        r_by  <= w_by;
        r_col <= mark_colour(w_gnt1 ? i_mark1 : i_mark0);
      end
    end
  assign o_ack0       = r_ack0;
  assign o_ack1       = r_ack1;
  assign o_err        = r_err;
  assign o_done       = r_done;
  assign o_busy       = r_busy;
  assign o_vga_x      = r_x;
  assign o_vga_y      = r_y;
  assign o_vga_colour = r_colour;
  assign o_vga_plot   = r_plot;
endmodule

// File: tb/tb_board_draw_scheduler.sv
// tb_board_draw_scheduler: table, hand-written and random requests checked against a cross-drawing model
module tb_board_draw_scheduler;
  localparam int W = 40;
  localparam int H = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [3:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [1:0] m0 = '0, m1 = '0;
  logic ack0, ack1, err, done, busy, plot;
  logic [8:0] vx;
  logic [7:0] vy;
  logic [2:0] vc;
  int n_chk = 0;
  int n_pass = 0;
  bit last_grant = 1'b1;
  typedef struct {
    bit p;
    int x, y, m;
    bit e;
    int fx, fy, fc;
  } vec_t;
  vec_t tbl[7];

  board_draw_scheduler #(.SCREEN_W(W), .SCREEN_H(H), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_req0(req0), .i_req1(req1),
    .i_x0(x0), .i_y0(y0), .i_x1(x1), .i_y1(y1), .i_mark0(m0), .i_mark1(m1),
    .o_ack0(ack0), .o_ack1(ack1), .o_err(err), .o_done(done), .o_busy(busy),
    .o_vga_x(vx), .o_vga_y(vy), .o_vga_colour(vc), .o_vga_plot(plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int colour_of(input int m);
    case (m)
      0: return 7;
      1: return 4;
      2: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic wait_ack(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        who = ack1 ? 1 : 0;
        break;
      end
    end
    if (who < 0) check("ack timeout", 0, 1);
  endtask

  // Called on the negedge where ack is visible; checks err, the 24-pixel cross and the done pulse.
  task automatic run_cross(input string tag, input int p, input int x, input int y, input int m,
                           output int fx, output int fy, output int fc, output int fe);
    int bx, by, col, ex, ey, plots, acks;
    bit bad;
    bad = x > 9 || y > 9;
    bx = (p == 1 ? 178 : 10) + 14 * x;
    by = 91 + 14 * y;
    col = colour_of(m);
    fe = err;
    fx = -1; fy = -1; fc = -1;
    plots = 0;
    acks = 0;
    check({tag, " err"}, err, bad);
    if (bad) begin
      repeat (30) begin
        @(negedge clk);
        plots += plot;
        acks += ack0 + ack1;
      end
      check({tag, " err plots"}, plots, 0);
      check({tag, " err acks"}, acks, 0);
      return;
    end
    for (int k = 0; k < 24; k++) begin
      ex = k < 12 ? bx + k : bx + 23 - k;
      ey = by + k % 12;
      @(negedge clk);
      if (k == 0) begin
        fx = vx; fy = vy; fc = vc;
      end
      acks += ack0 + ack1;
      check({tag, " plot"}, plot && busy, 1);
      check({tag, " x"}, vx, ex);
      check({tag, " y"}, vy, ey);
      check({tag, " colour"}, vc, col);
    end
    @(negedge clk);
    check({tag, " done"}, done, 1);
    check({tag, " done plot"}, plot || busy, 0);
    check({tag, " stray acks"}, acks, 0);
  endtask

  task automatic serve(input string tag, input bit r0, input bit r1, input int xa, input int ya,
                       input int ma, input int xb, input int yb, input int mb,
                       output int fx, output int fy, output int fc, output int fe);
    int who, cyc, exp_w;
    exp_w = (r0 && r1) ? (last_grant ? 0 : 1) : (r1 ? 1 : 0);
    if (r0 && r1) last_grant = exp_w[0];
    req0 = r0; req1 = r1;
    x0 = 4'(xa); y0 = 4'(ya); m0 = 2'(ma);
    x1 = 4'(xb); y1 = 4'(yb); m1 = 2'(mb);
    wait_ack(who, cyc);
    req0 = 1'b0; req1 = 1'b0;
    check({tag, " winner"}, who, exp_w);
    check({tag, " one ack"}, ack0 + ack1, 1);
    if (who == 1) run_cross(tag, 1, xb, yb, mb, fx, fy, fc, fe);
    else if (who == 0) run_cross(tag, 0, xa, ya, ma, fx, fy, fc, fe);
  endtask

  task automatic tie_test(input string tag);
    int who, cyc, first, fx, fy, fc, fe;
    first = last_grant ? 0 : 1;
    last_grant = first[0];
    req0 = 1'b1; req1 = 1'b1;
    x0 = 4'd1; y0 = 4'd2; m0 = 2'd1;
    x1 = 4'd3; y1 = 4'd4; m1 = 2'd2;
    wait_ack(who, cyc);
    check({tag, " first"}, who, first);
    if (first == 0) req0 = 1'b0; else req1 = 1'b0;
    run_cross({tag, " a"}, first, first ? 3 : 1, first ? 4 : 2, first ? 2 : 1, fx, fy, fc, fe);
    wait_ack(who, cyc);
    req0 = 1'b0; req1 = 1'b0;
    check({tag, " second"}, who, 1 - first);
    check({tag, " spacing"}, 25 + cyc, 26);
    run_cross({tag, " b"}, 1 - first, first ? 1 : 3, first ? 2 : 4, first ? 1 : 2, fx, fy, fc, fe);
  endtask

  // Starts on the negedge where reset is released; expects W*H clear pixels then done.
  task automatic check_clear(input string tag);
    int bad, plots, acks;
    bad = 0; plots = 0; acks = 0;
    for (int c = 1; c <= W * H; c++) begin
      @(negedge clk);
      plots += plot;
      acks += ack0 + ack1;
      if (!(plot && busy && !done && vx == (c - 1) % W && vy == (c - 1) / W && vc == 0)) bad++;
      if (c == 1) begin
        check({tag, " first x"}, vx, 0);
        check({tag, " first y"}, vy, 0);
      end
      if (c == W * H) begin
        check({tag, " last x"}, vx, W - 1);
        check({tag, " last y"}, vy, H - 1);
      end
    end
    check({tag, " plot count"}, plots, W * H);
    check({tag, " bad pixels"}, bad, 0);
    @(negedge clk);
    acks += ack0 + ack1;
    check({tag, " done"}, done, 1);
    check({tag, " done plot"}, plot, 0);
    check({tag, " acks"}, acks, 0);
  endtask

  initial begin
    int who, cyc, fx, fy, fc, fe, sel;
    tbl[0] = '{0, 5, 5, 0, 0,  80, 161, 7};
    tbl[1] = '{1, 5, 5, 1, 0, 248, 161, 4};
    tbl[2] = '{1, 9, 9, 2, 0, 304, 217, 5};
    tbl[3] = '{0, 10, 3, 0, 1,  0,   0, 0};
    tbl[4] = '{0, 0, 0, 3, 0,  10,  91, 0};
    tbl[5] = '{1, 3, 12, 1, 1,  0,   0, 0};
    tbl[6] = '{1, 0, 9, 0, 0, 178, 217, 7};
    repeat (3) @(negedge clk);
    check("reset plot", plot, 0);
    check("reset busy", busy, 0);
    check("reset flags", ack0 + ack1 + err + done, 0);
    check("reset x", vx, 0);
    check("reset y", vy, 0);
    rst_n = 1'b1;
    check_clear("clear1");
    @(negedge clk);
    check("busy after clear", busy, 0);
    tie_test("tie1");
    tie_test("tie2");
    foreach (tbl[i]) begin
      serve($sformatf("tbl%0d", i), !tbl[i].p, tbl[i].p, tbl[i].x, tbl[i].y, tbl[i].m,
            tbl[i].x, tbl[i].y, tbl[i].m, fx, fy, fc, fe);
      check($sformatf("tbl%0d err", i), fe, tbl[i].e);
      if (!tbl[i].e) begin
        check($sformatf("tbl%0d x0", i), fx, tbl[i].fx);
        check($sformatf("tbl%0d y0", i), fy, tbl[i].fy);
        check($sformatf("tbl%0d col", i), fc, tbl[i].fc);
      end
    end
    for (int n = 0; n < 25; n++) begin
      sel = $urandom_range(1, 3);
      serve($sformatf("rand%0d", n), sel[0], sel[1],
            $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3),
            $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3),
            fx, fy, fc, fe);
    end
    req0 = 1'b1; x0 = 4'd2; y0 = 4'd2; m0 = 2'd1;
    wait_ack(who, cyc);
    req0 = 1'b0;
    check("abort ack", who, 0);
    repeat (17) @(negedge clk);
    @(negedge clk);
    check("abort anti5 x", vx, 38 + 11 - 5);
    check("abort anti5 y", vy, 119 + 5);
    rst_n = 1'b0;
    req0 = 1'b1; x0 = 4'd4; y0 = 4'd1; m0 = 2'd2;
    last_grant = 1'b1;
    @(negedge clk);
    check("abort plot", plot, 0);
    check("abort busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_clear("clear2");
    wait_ack(who, cyc);
    req0 = 1'b0;
    check("pending ack who", who, 0);
    check("pending ack delay", cyc, 1);
    run_cross("pending", 0, 4, 1, 2, fx, fy, fc, fe);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
